// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int DEFAULT_W = 4;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, with a start/busy/done handshake.
// diff = X - Y mod 2^W; bout is the unsigned borrow and ovf is the signed overflow.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  sub_state_t   r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_res;
  logic         r_br;
  logic         r_sx;
  logic         r_sy;
  logic [CW-1:0] r_cnt;

  logic         w_d;
  logic         w_br_next;
  logic [W-1:0] w_res_next;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_next)
  );

  assign w_res_next = {w_d, r_res[W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= X;
            r_b     <= Y;
            r_sx    <= X[W-1];
            r_sy    <= Y[W-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          // The last bit edge publishes results directly so DONE shows them at once.
          if (r_cnt == CW'(W - 1)) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= w_res_next;
            bout    <= w_br_next;
            ovf     <= (r_sx != r_sy) & (w_d != r_sx);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at W=4.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] d;
    logic       b;
    logic       o;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Returns the number of sampled cycles after the accepting edge until done.
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] ed, input logic eb, input logic eo);
    int n;
    int bc;
    X = x;
    Y = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    wait_done(n, bc);
    chk("latency", n, W);
    chk("busy_cycles", bc, W);
    chk("busy_at_done", int'(busy), 0);
    chk("diff", int'(diff), int'(ed));
    chk("bout", int'(bout), int'(eb));
    chk("ovf", int'(ovf), int'(eo));
    tick();
    chk("done_pulse_width", int'(done), 0);
    chk("diff_held", int'(diff), int'(ed));
  endtask

  initial begin
    int n;
    int bc;
    int last_done;
    logic [3:0] cx;
    logic [3:0] cy;
    logic [3:0] sum;
    logic [8:0] nxt;

    vecs[0] = '{x: 4'b0101, y: 4'b0011, d: 4'b0010, b: 1'b0, o: 1'b0};
    vecs[1] = '{x: 4'b0011, y: 4'b0101, d: 4'b1110, b: 1'b1, o: 1'b0};
    vecs[2] = '{x: 4'b0000, y: 4'b0001, d: 4'b1111, b: 1'b1, o: 1'b0};
    vecs[3] = '{x: 4'b1000, y: 4'b0001, d: 4'b0111, b: 1'b0, o: 1'b1};
    vecs[4] = '{x: 4'b0111, y: 4'b1111, d: 4'b1000, b: 1'b1, o: 1'b1};
    vecs[5] = '{x: 4'b1111, y: 4'b1111, d: 4'b0000, b: 1'b0, o: 1'b0};
    vecs[6] = '{x: 4'b0000, y: 4'b1000, d: 4'b1000, b: 1'b1, o: 1'b1};
    vecs[7] = '{x: 4'b1001, y: 4'b0110, d: 4'b0011, b: 1'b0, o: 1'b1};

    rst_n = 1'b0;
    start = 1'b1;
    X = 4'hA;
    Y = 4'h3;
    tick();
    tick();
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    foreach (vecs[i]) run_op(vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].b, vecs[i].o);

    // Operands and start change during RUN; the original operation must win.
    X = 4'b1111;
    Y = 4'b1111;
    start = 1'b1;
    tick();
    X = 4'b0101;
    Y = 4'b1010;
    chk("mid_busy", int'(busy), 1);
    wait_done(n, bc);
    start = 1'b0;
    chk("mid_latency", n, W);
    chk("mid_diff", int'(diff), 0);
    chk("mid_bout", int'(bout), 0);
    chk("mid_ovf", int'(ovf), 0);
    start = 1'b1;
    tick();
    chk("start_in_done_ignored", int'(busy), 0);
    tick();
    start = 1'b0;
    chk("start_after_done_accepted", int'(busy), 1);
    wait_done(n, bc);
    chk("post_diff", int'(diff), 4'b1011);
    chk("post_bout", int'(bout), 1);
    chk("post_ovf", int'(ovf), 1);
    tick();

    // Reset on the second RUN edge aborts with no done pulse.
    X = 4'b0101;
    Y = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
    chk("abort_ovf", int'(ovf), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    bc = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || busy) bc++;
      tick();
    end
    chk("abort_no_activity", bc, 0);
    run_op(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);

    // Exhaustive sweep with start held high.
    X = 4'h0;
    Y = 4'h0;
    start = 1'b1;
    last_done = 0;
    for (int i = 0; i < 256; i++) begin
      cx = 4'(i >> 4);
      cy = 4'(i);
      wait_done(n, bc);
      sum = diff + cy;
      chk("sweep_sum", int'(sum), int'(cx));
      chk("sweep_bout", int'(bout), (cx < cy) ? 1 : 0);
      chk("sweep_ovf", int'(ovf),
          ((cx[3] != cy[3]) && (diff[3] != cx[3])) ? 1 : 0);
      if (i > 0) chk("sweep_period", cycle - last_done, W + 2);
      last_done = cycle;
      nxt = 9'(i + 1);
      X = nxt[7:4];
      Y = nxt[3:0];
      if (i == 255) start = 1'b0;
      tick();
    end
    for (int k = 0; k < 4; k++) tick();
    chk("sweep_end_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
